// File: rtl/cv32e40p_tb_mem_pkg.sv
// Shared types and constants for the bench OBI memory model: status register map,
// pass magic, the queued response entry and the debug view of the grant FSM.
package cv32e40p_tb_mem_pkg;

    localparam int          MEM_DATA_WIDTH  = 32;
    localparam logic [31:0] STATUS_PASS_OFF = 32'd0;
    localparam logic [31:0] STATUS_EXIT_OFF = 32'd4;
    localparam logic [31:0] TEST_PASS_MAGIC = 32'd123456789;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic [15:0]               stamp;
    } resp_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } gnt_state_e;

    typedef struct packed {
        gnt_state_e state;
        logic [7:0] outstanding;
    } mem_dbg_t;

endpackage

// File: rtl/cv32e40p_tb_obi_mem_if.sv
// OBI request/response bundle between one core port (master) and the memory model (slave).
// Handshake: a transaction transfers in a cycle with req_i && gnt_o; the master holds
// addr/we/be/wdata stable while req_i is high and ungranted; rvalid_o has no backpressure.
interface cv32e40p_tb_obi_mem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    req_i;
    logic                    gnt_o;
    logic [31:0]             addr_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/cv32e40p_tb_resp_fifo.sv
// In-order response queue; the entry count doubles as the outstanding-transaction count.
module cv32e40p_tb_resp_fifo
    import cv32e40p_tb_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  resp_entry_t   data_i,
    input  logic          pop_i,
    output resp_entry_t   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_tb_obi_mem.sv
// Stress-capable OBI slave for the bench: stalled grant, fixed-latency in-order responses,
// backing RAM and sticky pass/fail/exit status registers.
module cv32e40p_tb_obi_mem
    import cv32e40p_tb_mem_pkg::*;
#(
    parameter int          DATA_WIDTH      = MEM_DATA_WIDTH,
    parameter int          ADDR_WIDTH      = 20,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          GNT_STALL       = 0,
    parameter int          RVALID_LAT      = 1,
    parameter logic [31:0] STATUS_BASE     = 32'h2000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    cv32e40p_tb_obi_mem_if.slave        bus,
    input  logic                        stall_en_i,
    output logic                        tests_passed_o,
    output logic                        tests_failed_o,
    output logic                        exit_valid_o,
    output logic [31:0]                 exit_value_o,
    output mem_dbg_t                    dbg_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int WORDS = 2 ** (ADDR_WIDTH - OFF);
    localparam int SCW   = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam bit HAS_STALL = (GNT_STALL > 0);
    localparam logic [SCW-1:0] STALL_MAX = SCW'(GNT_STALL);
    localparam logic [15:0]    LAT16     = 16'(RVALID_LAT);

    gnt_state_e     state_q, state_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d, stall_inc;
    logic [15:0]    now_q, now_d;
    logic           passed_q, passed_d, failed_q, failed_d;
    logic           exit_valid_q, exit_valid_d;
    logic [31:0]    exit_value_q, exit_value_d;

    logic [DATA_WIDTH-1:0]       mem [WORDS];
    logic [ADDR_WIDTH-OFF-1:0]   word_idx;
    logic                        is_ram, is_pass, is_exit;
    logic                        gnt, accept, pop;
    logic                        fifo_full, fifo_empty;
    logic [CW-1:0]               fifo_count;
    resp_entry_t                 resp_new, resp_head;

    assign word_idx = bus.addr_i[ADDR_WIDTH-1:OFF];
    assign is_ram   = (bus.addr_i[31:ADDR_WIDTH] == '0);
    assign is_pass  = !is_ram && (bus.addr_i == STATUS_BASE + STATUS_PASS_OFF);
    assign is_exit  = !is_ram && (bus.addr_i == STATUS_BASE + STATUS_EXIT_OFF);
    assign stall_inc = stall_cnt_q + 1'b1;

    // ST_GRANT means the stall for the current request has been served; with stalling
    // disabled the grant ignores the state so a fresh request is granted immediately.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        gnt = rst_ni && bus.req_i && !fifo_full &&
              ((state_q == ST_GRANT) || !(stall_en_i && HAS_STALL));
        if (!bus.req_i) begin
            state_d     = ST_IDLE;
            stall_cnt_d = '0;
        end else if (gnt) begin
            state_d     = HAS_STALL ? ST_STALL : ST_GRANT;
            stall_cnt_d = '0;
        end else if (state_q != ST_GRANT) begin
            stall_cnt_d = stall_inc;
            state_d     = (stall_inc >= STALL_MAX) ? ST_GRANT : ST_STALL;
        end
    end

    assign accept = bus.req_i && gnt;

    always_comb begin
        passed_d     = passed_q;
        failed_d     = failed_q;
        exit_valid_d = exit_valid_q;
        exit_value_d = exit_value_q;
        now_d        = now_q + 16'd1;
        if (accept && bus.we_i) begin
            if (is_pass) begin
                if (bus.wdata_i[31:0] == TEST_PASS_MAGIC) passed_d = 1'b1;
                else                                      failed_d = 1'b1;
            end else if (is_exit) begin
                exit_valid_d = 1'b1;
                exit_value_d = bus.wdata_i[31:0];
            end
        end
        resp_new.rdata = (!bus.we_i && is_ram) ? mem[word_idx] : '0;
        resp_new.err   = !(is_ram || is_pass || is_exit);
        resp_new.stamp = now_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            stall_cnt_q  <= '0;
            now_q        <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            now_q        <= now_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && bus.we_i && is_ram) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.be_i[b]) mem[word_idx][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
            end
        end
    end

    cv32e40p_tb_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (resp_new),
        .pop_i   (pop),
        .data_o  (resp_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Modulo-2^16 age is exact because the latency is far below half the stamp range.
    assign pop          = !fifo_empty && ((now_q - resp_head.stamp) >= LAT16);
    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = pop;
    assign bus.rdata_o  = pop ? resp_head.rdata : '0;
    assign bus.err_o    = pop && resp_head.err;

    assign tests_passed_o    = passed_q;
    assign tests_failed_o    = failed_q;
    assign exit_valid_o      = exit_valid_q;
    assign exit_value_o      = exit_value_q;
    assign dbg_o.state       = state_q;
    assign dbg_o.outstanding = 8'(fifo_count);

endmodule
